// File: rtl/ps2_scancode_rx_if.sv
// PS/2 receiver link bundle: raw lines in, decoded scancode events out.
// master drives the PS/2 lines and consumes events; slave is the receiver.
interface ps2_scancode_rx_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       raw_valid;
  logic [7:0] raw_byte;
  logic       key_strobe;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_rel;
  logic       frame_err;
  logic       busy;

  modport master (
    output ps2_clk, ps2_dat,
    input  raw_valid, raw_byte, key_strobe, key_code,
    input  key_ext, key_rel, frame_err, busy
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output raw_valid, raw_byte, key_strobe, key_code,
    output key_ext, key_rel, frame_err, busy
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: sync, deglitch, deframe, parity/stop check,
// E0/F0 prefix folding into flags on the final key code.
module ps2_scancode_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic              clk_sys,
  input  logic              reset,
  ps2_scancode_rx_if.slave  bus
);

  localparam int TO_MAX = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int TO_W   = $clog2(TO_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic            clk_s1_q, clk_s2_q;
  logic            dat_s1_q, dat_s2_q;
  logic [3:0]      fcnt_q, fcnt_d;
  logic            filt_q, filt_d;
  logic            filt_prev_q;
  logic            fall;

  state_t          state_q, state_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            to_hit;
  logic            frame_done;
  logic            frame_ok;

  logic            ext_q, ext_d;
  logic            rel_q, rel_d;
  logic            raw_valid_q, raw_valid_d;
  logic [7:0]      raw_byte_q, raw_byte_d;
  logic            key_strobe_q, key_strobe_d;
  logic [7:0]      key_code_q, key_code_d;
  logic            key_ext_q, key_ext_d;
  logic            key_rel_q, key_rel_d;
  logic            frame_err_q, frame_err_d;
  logic            is_e0, is_f0, is_key;

  // Two-flop synchronisers; lines idle high
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= bus.ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= bus.ps2_dat;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Run filter: flip only after FILTER_LEN consecutive opposite samples
  always_comb begin
    fcnt_d = '0;
    filt_d = filt_q;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == 4'(FILTER_LEN - 1)) filt_d = ~filt_q;
      else fcnt_d = fcnt_q + 4'd1;
    end
  end

  // Filter state and previous filtered level for edge detect
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fcnt_q      <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      fcnt_q      <= fcnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
    end
  end

  assign fall   = filt_prev_q & ~filt_q;
  assign to_hit = (state_q != IDLE) && (to_q == TO_W'(TO_MAX));

  // Frame FSM next state; timeout takes priority over a same-cycle fall
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    if (to_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d = DATA;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          shreg_d = {dat_s2_q, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d    = IDLE;
          frame_done = 1'b1;
          frame_ok   = dat_s2_q & (^{shreg_q, par_q});
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Inter-edge gap counter; saturates, cleared by edges and in IDLE
  always_comb begin
    to_d = to_q;
    if (state_q == IDLE || fall) to_d = '0;
    else if (to_q != TO_W'(TO_MAX)) to_d = to_q + TO_W'(1);
  end

  assign is_e0  = (shreg_q == 8'hE0);
  assign is_f0  = (shreg_q == 8'hF0);
  assign is_key = frame_ok & ~is_e0 & ~is_f0;

  // Output/prefix-flag next state, all registered one cycle after the stop fall
  always_comb begin
    raw_valid_d  = frame_ok;
    raw_byte_d   = frame_ok ? shreg_q : raw_byte_q;
    key_strobe_d = is_key;
    key_code_d   = is_key ? shreg_q : key_code_q;
    key_ext_d    = is_key ? ext_q : key_ext_q;
    key_rel_d    = is_key ? rel_q : key_rel_q;
    frame_err_d  = to_hit | (frame_done & ~frame_ok);
    ext_d        = ext_q;
    rel_d        = rel_q;
    if (frame_ok && is_e0) begin
      ext_d = 1'b1;
    end else if (frame_ok && is_f0) begin
      rel_d = 1'b1;
    end else if (is_key || frame_err_d) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bcnt_q       <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      to_q         <= '0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      raw_valid_q  <= 1'b0;
      raw_byte_q   <= 8'h00;
      key_strobe_q <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_rel_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      to_q         <= to_d;
      ext_q        <= ext_d;
      rel_q        <= rel_d;
      raw_valid_q  <= raw_valid_d;
      raw_byte_q   <= raw_byte_d;
      key_strobe_q <= key_strobe_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_rel_q    <= key_rel_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.raw_valid  = raw_valid_q;
  assign bus.raw_byte   = raw_byte_q;
  assign bus.key_strobe = key_strobe_q;
  assign bus.key_code   = key_code_q;
  assign bus.key_ext    = key_ext_q;
  assign bus.key_rel    = key_rel_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
